// File: rtl/gray_src_counter.sv
// Binary count source for the binary-to-Gray converter stage.
// Runs one full modulo-2^W pass (up or down) under a valid/ready handshake,
// with preload, abort, wrap and completion pulses. All outputs are registers.
module gray_src_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         stop,
    input  logic         ready,
    output logic [W-1:0] count,
    output logic         valid,
    output logic         wrap,
    output logic         done,
    output logic         busy
);

    localparam int unsigned XW = W + 1;
    localparam logic [XW-1:0] PASS_LEN = {1'b1, {W{1'b0}}};
    localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [XW-1:0] xfer_q, xfer_d;
    logic          dir_q, dir_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          xfer_c;
    logic          step_wrap_c;
    logic [W-1:0]  count_step_c;
    logic [XW-1:0] xfer_inc_c;

    // Handshake decode and the candidate step for the current word
    always_comb begin
        xfer_c       = valid_q & ready;
        count_step_c = dir_q ? (count_q + W'(1)) : (count_q - W'(1));
        step_wrap_c  = dir_q ? (count_q == CNT_MAX) : (count_q == '0);
        xfer_inc_c   = xfer_q + XW'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        xfer_d  = xfer_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (load) begin
                    count_d = load_val;
                end
                if (start) begin
                    dir_d   = dir;
                    xfer_d  = '0;
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // A transfer always completes, even when it coincides with stop
                if (xfer_c) begin
                    count_d = count_step_c;
                    xfer_d  = xfer_inc_c;
                    wrap_d  = step_wrap_c;
                end
                if (xfer_c && (xfer_inc_c == PASS_LEN)) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (stop) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            xfer_q  <= '0;
            dir_q   <= 1'b1;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            xfer_q  <= xfer_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
